// File: rtl/fsm_sequencer.sv
// fsm_sequencer: drives a job through a core via four-phase command handshakes (RST, LOAD xNI, CALC, READ xNO)
//   clock, reset                       : rising-edge clock, synchronous active-high reset
//   job_valid/job_ready/job_data       : host job handshake and operand
//   res_valid/res_ready/res_data/res_err : result handshake, payload and error flag
//   busy                               : high whenever the sequencer is not idle
//   core_ctrl_out/core_ctrl_in         : command to core / status from core (ack = command | 8'h80)
//   core_data_out/core_data_in         : operand word or read index to core / result word from core
module fsm_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int BUFFER_IN_WIDTH = 16,
    parameter int BUFFER_OUT_WIDTH = 16,
    parameter int TIMEOUT = 255,
    parameter logic [7:0] CMD_IDLE = 8'd0,
    parameter logic [7:0] CMD_RST = 8'd1,
    parameter logic [7:0] CMD_CALC = 8'd2,
    parameter logic [7:0] CMD_LOAD = 8'd3,
    parameter logic [7:0] CMD_READ = 8'd4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [BUFFER_IN_WIDTH-1:0]  job_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [BUFFER_OUT_WIDTH-1:0] res_data,
    output logic                        res_err,
    output logic                        busy,
    output logic [7:0]                  core_ctrl_out,
    input  logic [7:0]                  core_ctrl_in,
    output logic [DATA_WIDTH-1:0]       core_data_out,
    input  logic [DATA_WIDTH-1:0]       core_data_in
);
    localparam int NI = (BUFFER_IN_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int NO = (BUFFER_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam logic [7:0] NI_LAST = 8'(NI - 1);
    localparam logic [7:0] NO_LAST = 8'(NO - 1);
    localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, RST, RST_REL, LOAD, LOAD_REL, CALC, CALC_REL, READ, READ_REL, DONE, ERROR
    } state_t;

    state_t st, st_n;
    logic [7:0] ctrl_q, idx, idx_n, tmr, tmr_n, cmd, exp_ack;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NI*DATA_WIDTH-1:0] job, job_n;
    logic [NO*DATA_WIDTH-1:0] res, res_n;
    logic rel, waiting, hit;

    // Command phases wait for cmd|0x80, release phases wait for the idle-ack 0x80;
    // any other status value simply burns a timeout cycle.
    always_comb begin
        cmd = (st == RST || st == RST_REL) ? CMD_RST :
              (st == LOAD || st == LOAD_REL) ? CMD_LOAD :
              (st == CALC || st == CALC_REL) ? CMD_CALC :
              (st == READ || st == READ_REL) ? CMD_READ : CMD_IDLE;
        rel = st inside {RST_REL, LOAD_REL, CALC_REL, READ_REL};
        waiting = !(st inside {IDLE, DONE, ERROR});
        exp_ack = rel ? (CMD_IDLE | 8'h80) : (cmd | 8'h80);
        hit = waiting && ctrl_q == exp_ack;
        st_n = st;
        idx_n = idx;
        job_n = job;
        res_n = res;
        case (st)
            IDLE: if (job_valid && job_ready) begin
                st_n = RST;
                job_n = '0;
                job_n[BUFFER_IN_WIDTH-1:0] = job_data;
            end
            RST: if (hit) st_n = RST_REL;
            RST_REL: if (hit) begin
                st_n = LOAD;
                idx_n = '0;
            end
            LOAD: if (hit) st_n = LOAD_REL;
            LOAD_REL: if (hit) begin
                st_n = idx == NI_LAST ? CALC : LOAD;
                idx_n = idx + 8'd1;
            end
            CALC: if (hit) st_n = CALC_REL;
            CALC_REL: if (hit) begin
                st_n = READ;
                idx_n = '0;
            end
            READ: if (hit) begin
                st_n = READ_REL;
                res_n[DATA_WIDTH*int'(idx) +: DATA_WIDTH] = data_q;
            end
            READ_REL: if (hit) begin
                st_n = idx == NO_LAST ? DONE : READ;
                idx_n = idx + 8'd1;
            end
            DONE, ERROR: if (res_ready) st_n = IDLE;
            default: st_n = IDLE;
        endcase
        if (waiting && !hit && tmr == T_LAST) st_n = ERROR;
        // LOAD_REL->LOAD and READ_REL->READ are state entries too, so the count restarts
        tmr_n = (waiting && st_n == st) ? tmr + 8'd1 : 8'd0;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            st <= IDLE;
            ctrl_q <= '0;
            data_q <= '0;
            idx <= '0;
            tmr <= '0;
            job <= '0;
            res <= '0;
            job_ready <= 1'b1;
            busy <= 1'b0;
            res_valid <= 1'b0;
            res_err <= 1'b0;
            res_data <= '0;
            core_ctrl_out <= CMD_IDLE;
            core_data_out <= '0;
        end else begin
            st <= st_n;
            ctrl_q <= core_ctrl_in;
            data_q <= core_data_in;
            idx <= idx_n;
            tmr <= tmr_n;
            job <= job_n;
            res <= res_n;
            job_ready <= st_n == IDLE;
            busy <= st_n != IDLE;
            res_valid <= st_n == DONE || st_n == ERROR;
            res_err <= st_n == ERROR;
            res_data <= st_n == DONE ? res_n[BUFFER_OUT_WIDTH-1:0] : '0;
            core_ctrl_out <= st_n == RST ? CMD_RST :
                             st_n == LOAD ? CMD_LOAD :
                             st_n == CALC ? CMD_CALC :
                             st_n == READ ? CMD_READ : CMD_IDLE;
            core_data_out <= st_n == LOAD ? job_n[DATA_WIDTH*int'(idx_n) +: DATA_WIDTH] :
                             st_n == READ ? DATA_WIDTH'(idx_n) : '0;
        end
    end
endmodule

// File: tb/tb_fsm_sequencer.sv
// tb_fsm_sequencer: directed checks of fsm_sequencer against a behavioural add-one core
module tb_fsm_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic job_valid = 1'b0;
    logic res_ready = 1'b0;
    logic [47:0] job_data = '0;
    logic job_ready, res_valid, res_err, busy;
    logic [15:0] res_data;
    logic [7:0] core_ctrl_out;
    logic [7:0] core_ctrl_in = 8'h80;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in = '0;
    int n_chk = 0;
    int n_fail = 0;
    int lat;
    logic no_calc = 1'b0;
    logic wrong_rst = 1'b0;
    logic log_clr = 1'b0;
    logic ld_idx = 1'b0;
    logic [31:0] mem0 = '0;
    logic [31:0] mem1 = '0;
    logic [47:0] calc_res = '0;
    logic [79:0] seq = '0;
    logic [7:0] last_cmd = '0;
    int calc_cnt = 0;
    logic seen;

    fsm_sequencer #(
        .DATA_WIDTH(32), .BUFFER_IN_WIDTH(48), .BUFFER_OUT_WIDTH(16), .TIMEOUT(10)
    ) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy),
        .core_ctrl_out(core_ctrl_out), .core_ctrl_in(core_ctrl_in),
        .core_data_out(core_data_out), .core_data_in(core_data_in)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (core_ctrl_out == 8'd1) ld_idx <= 1'b0;
        if (core_ctrl_out == 8'd3 && core_ctrl_in != 8'h83) begin
            if (ld_idx) mem1 <= core_data_out;
            else mem0 <= core_data_out;
            ld_idx <= ~ld_idx;
        end
        if (core_ctrl_out == 8'd2) calc_res <= {mem1[15:0], mem0} + 48'd1;
        if (core_ctrl_out == 8'd4) core_data_in <= core_data_out == 32'd0 ? calc_res[31:0] : {16'h0, calc_res[47:32]};
        core_ctrl_in <= core_ctrl_out == 8'd0 ? 8'h80 :
                        core_ctrl_out == 8'd1 ? (wrong_rst ? 8'h83 : 8'h81) :
                        core_ctrl_out == 8'd2 ? (no_calc ? 8'h80 : 8'h82) : (core_ctrl_out | 8'h80);
    end

    always @(posedge clock) begin
        if (log_clr) begin
            seq <= '0;
            last_cmd <= '0;
            calc_cnt <= 0;
        end else begin
            if (core_ctrl_out != last_cmd) begin
                seq <= {seq[71:0], core_ctrl_out};
                last_cmd <= core_ctrl_out;
            end
            if (core_ctrl_out == 8'd2) calc_cnt <= calc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clock);
        log_clr = 1'b1;
        @(negedge clock);
        log_clr = 1'b0;
    endtask

    task automatic start_job(input logic [47:0] d);
        @(negedge clock);
        check("job_ready before job", job_ready, 1);
        job_valid = 1'b1;
        job_data = d;
        @(posedge clock);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_res(output int l);
        l = 0;
        while (l < 200) begin
            @(negedge clock);
            if (res_valid) break;
            l++;
        end
        check("res_valid arrives", res_valid, 1);
    endtask

    task automatic ack_res();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check("idle after ack", {res_valid, job_ready, busy}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("reset job_ready", job_ready, 1);
        check("reset res_valid", res_valid, 0);
        check("reset res_err", res_err, 0);
        check("reset res_data", res_data, 0);
        check("reset busy", busy, 0);
        check("reset core_ctrl_out", core_ctrl_out, 0);
        check("reset core_data_out", core_data_out, 0);
        reset = 1'b0;

        clear_log();
        start_job(48'h5);
        wait_res(lat);
        check("job5 latency", lat, 30);
        check("job5 res_data", res_data, 16'h0006);
        check("job5 res_err", res_err, 0);
        check("job5 busy/job_ready", {busy, job_ready}, 2'b10);
        check("job5 core_data_out in DONE", core_data_out, 0);
        check("job5 load word0", mem0, 32'h5);
        check("job5 load word1", mem1, 32'h0);
        check("job5 command sequence", seq, 80'h01000300030002000400);
        ack_res();

        clear_log();
        start_job(48'hABCD_1234_5678);
        wait_res(lat);
        check("wide latency", lat, 30);
        check("wide load word0", mem0, 32'h1234_5678);
        check("wide load word1", mem1, 32'h0000_ABCD);
        check("wide res", {res_err, res_data}, {1'b0, 16'h5679});
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("hold valid/ready/data", {res_valid, job_ready, res_data}, {1'b1, 1'b0, 16'h5679});
        end
        ack_res();

        no_calc = 1'b1;
        clear_log();
        start_job(48'h7);
        wait_res(lat);
        check("timeout latency", lat, 28);
        check("timeout calc cycles", calc_cnt, 10);
        check("timeout res_err", res_err, 1);
        check("timeout res_data", res_data, 0);
        check("timeout core_ctrl_out", core_ctrl_out, 0);
        no_calc = 1'b0;
        ack_res();

        wrong_rst = 1'b1;
        clear_log();
        start_job(48'h9);
        wait_res(lat);
        check("wrong ack latency", lat, 10);
        check("wrong ack res_err", res_err, 1);
        wrong_rst = 1'b0;
        ack_res();
        check("wrong ack never left RST", seq, 80'h0100);

        start_job(48'h33);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = core_ctrl_out == 8'd2;
        end
        check("reached CALC", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = core_ctrl_out == 8'd0;
        end
        check("reached CALC_REL", seen, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid reset outputs", {job_ready, res_valid, res_err, busy, res_data, core_ctrl_out, core_data_out},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 32'h0});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen = seen | res_valid | busy;
        end
        check("no result after reset", seen, 0);
        clear_log();
        start_job(48'hFF);
        wait_res(lat);
        check("post reset latency", lat, 30);
        check("post reset res", {res_err, res_data}, {1'b0, 16'h0100});
        ack_res();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsm_sequencer.md
FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, core data bus width.
REQ-002 Parameter BUFFER_IN_WIDTH, default 16, job operand width.
REQ-003 Parameter BUFFER_OUT_WIDTH, default 16, result width.
REQ-004 Parameter TIMEOUT, default 255, max wait cycles per handshake phase (1..255).
REQ-005 Parameters CMD_IDLE=0, CMD_RST=1, CMD_CALC=2, CMD_LOAD=3, CMD_READ=4, 8-bit command codes.
REQ-006 clock  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 job_valid  in  1 / job_ready  out  1 / job_data  in  BUFFER_IN_WIDTH  host job handshake and operand.
REQ-009 res_valid  out  1 / res_ready  in  1 / res_data  out  BUFFER_OUT_WIDTH / res_err  out  1  result handshake, payload, error flag.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 core_ctrl_out  out  8  command to core ctrl_in; core_ctrl_in  in  8  status from core ctrl_out.
REQ-012 core_data_out  out  DATA_WIDTH  to core data_in; core_data_in  in  DATA_WIDTH  from core data_out.

Function
REQ-013 core_ctrl_in and core_data_in SHALL be registered once before any use; all ack decisions use registered values.
REQ-014 Ack for command C SHALL be registered core_ctrl_in == (C | 8'h80); idle-ack SHALL be 8'h80.
REQ-015 Each core command SHALL be a four-phase handshake: drive C until ack(C), then drive CMD_IDLE until idle-ack.
REQ-016 States: IDLE, RST, RST_REL, LOAD, LOAD_REL, CALC, CALC_REL, READ, READ_REL, DONE, ERROR.
REQ-017 job_ready SHALL be 1 only in IDLE; on job_valid&job_ready, job_data latched, next state RST.
REQ-018 RST drives CMD_RST; ack -> RST_REL; idle-ack -> LOAD with word index 0.
REQ-019 NI = ceil(BUFFER_IN_WIDTH/DATA_WIDTH); LOAD k drives CMD_LOAD, core_data_out = operand word k (LSB-first, zero-padded above BUFFER_IN_WIDTH).
REQ-020 LOAD_REL idle-ack: if k==NI-1 -> CALC, else k+1 -> LOAD.
REQ-021 CALC drives CMD_CALC; ack -> CALC_REL; idle-ack -> READ with index 0.
REQ-022 NO = ceil(BUFFER_OUT_WIDTH/DATA_WIDTH); READ k drives CMD_READ, core_data_out = k; on ack, registered core_data_in captured into result word k.
REQ-023 READ_REL idle-ack: if k==NO-1 -> DONE, else k+1 -> READ.
REQ-024 core_data_out SHALL be 0 in all states other than LOAD and READ.
REQ-025 Timeout counter SHALL clear on every state entry; reaching TIMEOUT cycles in any wait state -> ERROR, core_ctrl_out = CMD_IDLE.
REQ-026 DONE: res_valid=1, res_err=0, res_data = captured result truncated to BUFFER_OUT_WIDTH.
REQ-027 ERROR: res_valid=1, res_err=1, res_data=0.
REQ-028 res_data/res_err SHALL hold stable while res_valid&!res_ready; on res_valid&res_ready -> IDLE next cycle.
REQ-029 Ack matching a command other than the one driven SHALL be ignored (counts toward timeout).
REQ-030 Job-to-result latency with zero-delay core (ack one cycle after command) SHALL be deterministic and equal for every job of equal NI/NO.

Reset
REQ-031 On reset: state IDLE, job_ready=1, res_valid=0, res_err=0, res_data=0, busy=0, core_ctrl_out=CMD_IDLE, core_data_out=0, counters and index 0.
REQ-032 Reset in any state, including mid-handshake, SHALL take effect next edge and discard the in-flight job without producing a result.

Verification
REQ-033 Defaults, core model adds 1: job_data=0x0005 -> one result res_data=0x0006, res_err=0, command sequence RST, LOAD, CALC, READ, each followed by IDLE.
REQ-034 BUFFER_IN_WIDTH=48, DATA_WIDTH=32, job_data=0xABCD_1234_5678 -> LOAD words 0x1234_5678 then 0x0000_ABCD.
REQ-035 Core never acks CMD_CALC, TIMEOUT=10 -> ERROR after 10 wait cycles in CALC, res_err=1, res_data=0, core_ctrl_out=CMD_IDLE.
REQ-036 res_ready held 0 for 20 cycles after DONE -> res_valid and res_data constant, job_ready=0, then IDLE one cycle after res_ready=1.
REQ-037 reset asserted one cycle while in CALC_REL -> all outputs at reset values, no res_valid; next job 0x00FF completes with 0x0100.
REQ-038 Core returns ack(CMD_LOAD) while CMD_RST driven -> ignored, state stays RST until correct ack or timeout.
